gray_count_rx: RTL and testbench



---
 rtl/gray_count_rx_if.sv | 26 ++
 rtl/gray_count_rx.sv | 111 +++++++++++
 tb/tb_gray_count_rx.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/gray_count_rx_if.sv
// Bundle of the Gray-counter receiver's data signals: the raw Gray bus and clear in,
// the decoded count, increment, accumulated total and error flags out.
interface gray_count_rx_if #(
    parameter int WIDTH     = 2,
    parameter int ACC_WIDTH = 16
);
    logic [WIDTH-1:0]     gray_in;
    logic                 clr;
    logic [WIDTH-1:0]     count_bin;
    logic [WIDTH-1:0]     delta;
    logic                 inc_pulse;
    logic [ACC_WIDTH-1:0] total;
    logic                 sat;
    logic                 err_multi;
    logic                 err_sticky;

    modport master (
        output gray_in, clr,
        input  count_bin, delta, inc_pulse, total, sat, err_multi, err_sticky
    );

    modport slave (
        input  gray_in, clr,
        output count_bin, delta, inc_pulse, total, sat, err_multi, err_sticky
    );
endinterface

// File: rtl/gray_count_rx.sv
// Consumer end of a Gray-coded counter CDC: synchronize, decode to binary, measure the
// per-sample increment, accumulate it into a saturating total and flag lossy crossings.
module gray_count_rx #(
    parameter int WIDTH       = 2,
    parameter int SYNC_STAGES = 4,
    parameter int ACC_WIDTH   = 16
) (
    input  logic             clk_out,
    input  logic             rst,
    gray_count_rx_if.slave   bus
);
    localparam logic [ACC_WIDTH-1:0] ACC_MAX = '1;
    localparam int                   PAD     = ACC_WIDTH + 1 - WIDTH;

    logic [WIDTH-1:0]     sync_q [SYNC_STAGES];
    logic [WIDTH-1:0]     sync_d [SYNC_STAGES];
    logic [WIDTH-1:0]     gray_prev_q, gray_prev_d;
    logic [WIDTH-1:0]     bin_prev_q, bin_prev_d;
    logic [WIDTH-1:0]     count_bin_q, count_bin_d;
    logic [WIDTH-1:0]     delta_q, delta_d;
    logic                 inc_pulse_q, inc_pulse_d;
    logic                 err_multi_q, err_multi_d;
    logic                 err_sticky_q, err_sticky_d;
    logic [ACC_WIDTH-1:0] total_q, total_d;
    logic                 sat_q, sat_d;

    logic [WIDTH-1:0]     gray_s;
    logic [WIDTH-1:0]     bin_s;
    logic [ACC_WIDTH-1:0] acc_base;
    logic [ACC_WIDTH:0]   acc_sum;
    logic                 acc_hit;

    function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    always_comb begin
        sync_d[0] = bus.gray_in;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    assign gray_s = sync_q[SYNC_STAGES-1];

    // Stage 1: decode and compare against the previous sample.
    // NOTE: every signal written here gets a value on every path, so no latch is inferred.
    always_comb begin
        bin_s        = gray2bin(gray_s);
        count_bin_d  = bin_s;
        delta_d      = bin_s - bin_prev_q;
        inc_pulse_d  = |delta_d;
        err_multi_d  = $countones(gray_s ^ gray_prev_q) > 1;
        gray_prev_d  = gray_s;
        bin_prev_d   = bin_s;
        err_sticky_d = (err_sticky_q & ~bus.clr) | err_multi_d;
    end

    // Stage 2: clear-then-add, clamped at the all-ones maximum.
    always_comb begin
        acc_base = bus.clr ? '0 : total_q;
        acc_sum  = {1'b0, acc_base} + {{PAD{1'b0}}, delta_q};
        acc_hit  = acc_sum >= {1'b0, ACC_MAX};
        total_d  = acc_hit ? ACC_MAX : acc_sum[ACC_WIDTH-1:0];
        sat_d    = (sat_q & ~bus.clr) | acc_hit;
    end

    // NOTE: the synchronizer array is reset too, so stale source values never survive rst.
    always_ff @(posedge clk_out) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            gray_prev_q  <= '0;
            bin_prev_q   <= '0;
            count_bin_q  <= '0;
            delta_q      <= '0;
            inc_pulse_q  <= 1'b0;
            err_multi_q  <= 1'b0;
            err_sticky_q <= 1'b0;
            total_q      <= '0;
            sat_q        <= 1'b0;
        end else begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_d[i];
            end
            gray_prev_q  <= gray_prev_d;
            bin_prev_q   <= bin_prev_d;
            count_bin_q  <= count_bin_d;
            delta_q      <= delta_d;
            inc_pulse_q  <= inc_pulse_d;
            err_multi_q  <= err_multi_d;
            err_sticky_q <= err_sticky_d;
            total_q      <= total_d;
            sat_q        <= sat_d;
        end
    end

    assign bus.count_bin  = count_bin_q;
    assign bus.delta      = delta_q;
    assign bus.inc_pulse  = inc_pulse_q;
    assign bus.err_multi  = err_multi_q;
    assign bus.err_sticky = err_sticky_q;
    assign bus.total      = total_q;
    assign bus.sat        = sat_q;
endmodule

// File: tb/tb_gray_count_rx.sv
// Bench for gray_count_rx: a wide (16-bit) and a narrow (4-bit) accumulator instance share
// one stimulus; a sample-level model is compared every cycle alongside directed checks.
module tb_gray_count_rx;
    localparam int W    = 2;
    localparam int S    = 4;
    localparam int AW   = 16;
    localparam int AWS  = 4;
    localparam int MODW = 1 << W;

    typedef struct {
        logic [W-1:0] gray;
        int           exp_count;
        int           exp_delta;
        int           exp_err;
        int           exp_total;
    } vec_t;

    logic         clk_out = 1'b0;
    logic         rst;
    logic         clr;
    logic [W-1:0] gray_in;

    int n_checks = 0;
    int n_pass   = 0;
    bit model_en = 1'b0;

    // Model state: a delay line of source samples plus per-sample results.
    int pipe[$];
    int prev_g, prev_b, m_count, m_delta, m_inc, m_err, m_sticky;
    int tot[2];
    int satm[2];
    int maxv[2];

    vec_t tbl [6];

    always #5 clk_out = ~clk_out;

    gray_count_rx_if #(.WIDTH(W), .ACC_WIDTH(AW))  bus_a ();
    gray_count_rx_if #(.WIDTH(W), .ACC_WIDTH(AWS)) bus_b ();

    assign bus_a.gray_in = gray_in;
    assign bus_a.clr     = clr;
    assign bus_b.gray_in = gray_in;
    assign bus_b.clr     = clr;

    gray_count_rx #(.WIDTH(W), .SYNC_STAGES(S), .ACC_WIDTH(AW)) u_dut (
        .clk_out (clk_out),
        .rst     (rst),
        .bus     (bus_a)
    );

    gray_count_rx #(.WIDTH(W), .SYNC_STAGES(S), .ACC_WIDTH(AWS)) u_sat (
        .clk_out (clk_out),
        .rst     (rst),
        .bus     (bus_b)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic int g2b(input int g);
        int b = 0;
        for (int s = 0; s < W; s++) b = b ^ (g >> s);
        return b % MODW;
    endfunction

    function automatic int ones(input int v);
        int n = 0;
        for (int i = 0; i < 32; i++) n += (v >> i) & 1;
        return n;
    endfunction

    function automatic logic [63:0] dut_vec();
        return {28'd0,
                bus_b.count_bin, bus_b.delta, bus_b.inc_pulse, bus_b.err_multi,
                bus_b.err_sticky, bus_b.total, bus_b.sat,
                bus_a.count_bin, bus_a.delta, bus_a.inc_pulse, bus_a.err_multi,
                bus_a.err_sticky, bus_a.total, bus_a.sat};
    endfunction

    function automatic logic [63:0] model_vec();
        return {28'd0,
                W'(m_count), W'(m_delta), 1'(m_inc), 1'(m_err), 1'(m_sticky),
                AWS'(tot[1]), 1'(satm[1]),
                W'(m_count), W'(m_delta), 1'(m_inc), 1'(m_err), 1'(m_sticky),
                AW'(tot[0]), 1'(satm[0])};
    endfunction

    // One clk_out edge of the specified behaviour, using the inputs present at that edge.
    task automatic model_step();
        int g, b, d, e, s;
        if (rst) begin
            pipe = {};
            for (int i = 0; i < S; i++) pipe.push_back(0);
            prev_g = 0; prev_b = 0;
            m_count = 0; m_delta = 0; m_inc = 0; m_err = 0; m_sticky = 0;
            for (int k = 0; k < 2; k++) begin
                tot[k] = 0; satm[k] = 0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                s       = (clr ? 0 : tot[k]) + m_delta;
                tot[k]  = (s > maxv[k]) ? maxv[k] : s;
                satm[k] = ((clr ? 0 : satm[k]) != 0 || tot[k] == maxv[k]) ? 1 : 0;
            end
            g = pipe.pop_front();
            pipe.push_back(int'(gray_in));
            b = g2b(g);
            d = (b - prev_b + MODW) % MODW;
            e = (ones(g ^ prev_g) > 1) ? 1 : 0;
            m_sticky = ((clr ? 0 : m_sticky) != 0 || e != 0) ? 1 : 0;
            m_count = b; m_delta = d; m_inc = (d != 0) ? 1 : 0; m_err = e;
            prev_g = g; prev_b = b;
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk_out);
            @(negedge clk_out);
            model_step();
            if (model_en) check("model", dut_vec(), model_vec());
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int b;
        int pulses;
        maxv[0] = (1 << AW) - 1;
        maxv[1] = (1 << AWS) - 1;
        for (int i = 0; i < S; i++) pipe.push_back(0);

        tbl = '{
            '{2'b00, 0, 0, 0, 0},
            '{2'b01, 1, 1, 0, 1},
            '{2'b11, 2, 1, 0, 2},
            '{2'b10, 3, 1, 0, 3},
            '{2'b00, 0, 1, 0, 4},
            '{2'b11, 2, 2, 1, 6}
        };

        // Reset with a nonzero source value waiting at the input.
        rst = 1'b1; clr = 1'b0; gray_in = 2'b10;
        model_en = 1'b1;
        tick(3);
        check("rst_count", bus_a.count_bin, 0);
        check("rst_delta", bus_a.delta, 0);
        check("rst_inc",   bus_a.inc_pulse, 0);
        check("rst_total", bus_a.total, 0);
        check("rst_flags", {bus_a.sat, bus_a.err_multi, bus_a.err_sticky}, 0);
        rst = 1'b0;
        tick(S);
        check("latency_hold_count", bus_a.count_bin, 0);
        tick(1);
        check("first_count", bus_a.count_bin, 3);
        check("first_delta", bus_a.delta, 3);
        check("first_inc",   bus_a.inc_pulse, 1);
        tick(1);
        check("first_total", bus_a.total, 3);
        check("first_inc_drop", bus_a.inc_pulse, 0);

        gray_in = 2'b00;
        tick(8);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        check("clr_total_a", bus_a.total, 0);
        check("clr_total_b", bus_b.total, 0);

        // Single steps through a full wrap, then a two-bit jump.
        for (int i = 0; i < 6; i++) begin
            gray_in = tbl[i].gray;
            tick(S + 1);
            check($sformatf("vec%0d_count", i), bus_a.count_bin, tbl[i].exp_count);
            check($sformatf("vec%0d_delta", i), bus_a.delta, tbl[i].exp_delta);
            check($sformatf("vec%0d_inc", i), bus_a.inc_pulse, (tbl[i].exp_delta != 0) ? 1 : 0);
            check($sformatf("vec%0d_err", i), bus_a.err_multi, tbl[i].exp_err);
            tick(1);
            check($sformatf("vec%0d_total", i), bus_a.total, tbl[i].exp_total);
            check($sformatf("vec%0d_pulse_end", i), {bus_a.inc_pulse, bus_a.err_multi}, 0);
            tick(6);
        end
        check("multi_sticky", bus_a.err_sticky, 1);

        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        check("clr_sticky", bus_a.err_sticky, 0);
        check("clr_total",  bus_a.total, 0);
        check("clr_keeps_count", bus_a.count_bin, 2);

        // Saturation of the 4-bit accumulator.
        b = 2;
        for (int i = 0; i < 15; i++) begin
            b = (b + 1) % MODW;
            gray_in = W'(b ^ (b >> 1));
            tick(3);
        end
        tick(S + 2);
        check("sat15_total_b", bus_b.total, 15);
        check("sat15_total_a", bus_a.total, 15);
        b = (b + 1) % MODW;
        gray_in = W'(b ^ (b >> 1));
        tick(S + 2);
        check("sat16_total_b", bus_b.total, 15);
        check("sat16_sat_b",   bus_b.sat, 1);
        check("sat16_total_a", bus_a.total, 16);
        check("sat16_sat_a",   bus_a.sat, 0);
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            b = (b + 1) % MODW;
            gray_in = W'(b ^ (b >> 1));
            for (int j = 0; j < 3; j++) begin
                tick(1);
                if (bus_b.inc_pulse) pulses++;
            end
        end
        for (int j = 0; j < S + 2; j++) begin
            tick(1);
            if (bus_b.inc_pulse) pulses++;
        end
        check("sat_inc_pulses", pulses, 4);
        check("sat_hold_total_b", bus_b.total, 15);
        check("sat_hold_total_a", bus_a.total, 20);

        // Clear on the very edge that adds a delta of one.
        gray_in = 2'b10;
        tick(S + 1);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        check("clr_add_total_a", bus_a.total, 1);
        check("clr_add_total_b", bus_b.total, 1);
        check("clr_add_sat_b",   bus_b.sat, 0);

        // Reset while a change is still inside the synchronizer.
        gray_in = 2'b11;
        tick(2);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("midrst_outputs", dut_vec(), 0);
        tick(S);
        check("midrst_lost", bus_a.count_bin, 0);
        tick(1);
        check("midrst_count", bus_a.count_bin, 2);
        check("midrst_delta", bus_a.delta, 2);
        check("midrst_err",   bus_a.err_multi, 1);

        // Randomized traffic: holds, single-bit steps, arbitrary jumps, clears, resets.
        for (int i = 0; i < 3000; i++) begin
            int r;
            r   = int'($urandom_range(0, 99));
            rst = (r < 2);
            clr = ($urandom_range(0, 24) == 0);
            if (r >= 92)      gray_in = W'($urandom_range(0, MODW - 1));
            else if (r >= 55) gray_in = gray_in ^ W'(1 << $urandom_range(0, W - 1));
            tick(1);
        end
        rst = 1'b0;
        clr = 1'b0;
        tick(S + 2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
